fp_sign_unit_pipe: RTL and testbench
====================================

// Module: fp_sign_unit_pipe
// PURPOSE
//  Parametrised, pipelined IEEE-754 sign-manipulation unit: NEG, ABS, MOV, COPYSIGN, NCOPYSIGN, XORSIGN.
//  Classifies operand A (qNaN/sNaN/inf/zero/subnormal) and never raises FP exceptions.
//  Sits in the FPU issue path beside add/mul; uses valid/ready so it shares the FPU writeback arbiter.
// PARAMETERS
//  EXP_W          8   exponent width (8 = single, 11 = double)
//  MAN_W          23  fraction width (23 = single, 52 = double); W = 1+EXP_W+MAN_W
//  STAGES         2   pipeline register slices, legal 1..4
//  TAG_W          5   opaque tag (dest reg id) carried alongside data
//  NEG_ZERO_POS   1   1: NEG of +0 yields +0 (legacy MIPS behaviour); 0: IEEE (-0)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand/op valid
//  in_ready   out  1      unit can accept this cycle
//  in_op      in   3      fp_pkg::sign_op_e
//  in_a       in   W      operand A (magnitude source, classified)
//  in_b       in   W      operand B (sign source for COPYSIGN/NCOPYSIGN/XORSIGN; ignored otherwise)
//  in_tag     in   TAG_W  passthrough tag
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts
//  out_result out  W      result
//  out_tag    out  TAG_W  tag matching out_result
//  out_qnan   out  1      A is quiet NaN (exp all-1, frac MSB 1)
//  out_snan   out  1      A is signalling NaN (exp all-1, frac MSB 0, frac != 0)
//  out_inf    out  1      A is +/-inf
//  out_zero   out  1      A is +/-0
//  out_subn   out  1      A is subnormal (exp 0, frac != 0)
// BEHAVIOUR
//  - Reset (async assert, sync deassert is caller's job): all stage valids 0; out_valid=0; all
//    out_* data/flags 0; in_ready=1 one cycle after release.
//  - Result (s=A sign, sb=B sign, m=A[W-2:0]): NEG {~s,m}; ABS {0,m}; MOV A; COPYSIGN {sb,m};
//    NCOPYSIGN {~sb,m}; XORSIGN {s^sb,m}. Reserved op codes return A unchanged, flags valid.
//  - NaN payloads preserved bit-exact; sNaN is NOT quieted; only the sign bit ever changes.
//  - NEG_ZERO_POS=1: NEG of A==+0 returns +0; NEG of -0 returns +0. Other ops unaffected.
//  - Flags are mutually exclusive and describe A regardless of op.
//  - Latency: exactly STAGES cycles in_valid&in_ready -> out_valid when out_ready held 1.
//  - Handshake: transfer on valid&ready. Stage k loads when its output is empty or being
//    drained; in_ready = ~v[0] | ready_into_stage0 (bubble-collapsing, combinational ready
//    chain). Full throughput 1/cycle with out_ready=1.
//  - out_valid, once high, holds with out_* stable until out_ready (no retraction, no change).
//  - in_valid low: no state change except draining. Payload ignored when in_valid=0.
//  - Backpressure with all STAGES full: in_ready=0; no data lost, order preserved (in-order FIFO).
//  - Simultaneous accept at input and drain at output when full: both occur, occupancy unchanged.
//  - Reset mid-operation: all in-flight ops discarded, no output beat emitted.
// STRUCTURE
//  - fp_pkg: sign_op_e {OP_MOV=0,OP_NEG,OP_ABS,OP_CPS,OP_NCPS,OP_XORS}; fp_class_t packed struct
//    {qnan,snan,inf,zero,subn}; function fp_classify(exp,frac). Shared with other FPU units.
//  - Compute (op decode + classify) combinational before stage 0; stages carry
//    {result,tag,class}.
//  - Sub-module fp_pipe_slice #(DW): one valid/ready register slice, instantiated STAGES times
//    via generate.
// TESTING
//  1 NEG single 0x3F800000, out_ready=1 -> 0xBF800000 after 2 cycles, all flags 0.
//  2 NEG 0x7FC00001 (qNaN) -> 0xFFC00001, out_qnan=1; NEG 0x7F800001 -> 0xFF800001, out_snan=1.
//  3 NEG 0x00000000: NEG_ZERO_POS=1 -> 0x00000000, zero=1; NEG_ZERO_POS=0 -> 0x80000000.
//  4 COPYSIGN a=0x40490FDB b=0x80000000 -> 0xC0490FDB; XORSIGN a=0xC0000000 b=0x80000000
//    -> 0x40000000; ABS of 0xFF800000 -> 0x7F800000, inf=1.
//  5 Stream 8 ops tags 0..7, out_ready toggles 1,0,0,1,...: outputs in tag order, no loss/dup,
//    in_ready=0 only when STAGES slots full; outputs stable while stalled.
//  6 Reset asserted with 2 ops in flight -> out_valid=0 immediately; no stale beat after release;
//    double params (EXP_W=11, MAN_W=52) NEG 0x3FF0000000000000 -> 0xBFF0000000000000.

Source files
------------

// File: rtl/fp_sign_unit_pipe_pkg.sv
// Shared FPU definitions: sign-op codes, operand class flags and the classifier.
package fp_pkg;

    // Widest exponent/fraction the classifier accepts (covers single and double).
    localparam int FP_EXP_MAX = 16;
    localparam int FP_MAN_MAX = 64;

    typedef enum logic [2:0] {
        OP_MOV  = 3'd0,
        OP_NEG  = 3'd1,
        OP_ABS  = 3'd2,
        OP_CPS  = 3'd3,
        OP_NCPS = 3'd4,
        OP_XORS = 3'd5
    } sign_op_e;

    typedef struct packed {
        logic qnan;
        logic snan;
        logic inf;
        logic zero;
        logic subn;
    } fp_class_t;

    localparam int FP_CLASS_W = $bits(fp_class_t);

    // Caller zero-extends exp/frac to the maximum widths and passes the real widths;
    // the flags come out mutually exclusive by construction.
    function automatic fp_class_t fp_classify(
        input logic [FP_EXP_MAX-1:0] exp,
        input logic [FP_MAN_MAX-1:0] frac,
        input int                    exp_w,
        input int                    man_w
    );
        fp_class_t             c;
        logic [FP_EXP_MAX-1:0] mask;
        logic                  exp_ones;
        logic                  exp_zero;
        logic                  frac_nz;
        logic                  frac_msb;
        mask     = ~({FP_EXP_MAX{1'b1}} << exp_w);
        exp_ones = ((exp & mask) == mask);
        exp_zero = ((exp & mask) == '0);
        frac_nz  = (frac != '0);
        frac_msb = frac[6'(man_w - 1)];
        c        = '0;
        c.qnan   = exp_ones & frac_msb;
        c.snan   = exp_ones & ~frac_msb & frac_nz;
        c.inf    = exp_ones & ~frac_nz;
        c.zero   = exp_zero & ~frac_nz;
        c.subn   = exp_zero & frac_nz;
        return c;
    endfunction

endpackage

// File: rtl/fp_sign_unit_pipe_slice.sv
// One valid/ready register slice. Loads whenever it is empty or its content is
// leaving this cycle, so bubbles collapse; held data never changes while stalled.
module fp_pipe_slice #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          w_load;

    assign w_load  = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // Slice register: take a new beat (or a bubble) when the slot frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/fp_sign_unit_pipe.sv
// Pipelined IEEE-754 sign-manipulation unit. Result and class of A are computed
// combinationally ahead of stage 0; STAGES slices carry {result, tag, class}.
module fp_sign_unit_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W        = 8,
    parameter int MAN_W        = 23,
    parameter int STAGES       = 2,
    parameter int TAG_W        = 5,
    parameter int NEG_ZERO_POS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_result,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_qnan,
    output logic                     out_snan,
    output logic                     out_inf,
    output logic                     out_zero,
    output logic                     out_subn
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int DW = W + TAG_W + FP_CLASS_W;

    logic            r_rst_done;
    logic            w_s;
    logic            w_sb;
    logic            w_new_sign;
    logic [W-2:0]    w_mag;
    logic [W-1:0]    w_res;
    fp_class_t       w_cls;
    fp_class_t       w_out_cls;
    logic [DW-1:0]   w_pack;
    logic            w_unused_b;

    logic [STAGES-1:0] w_vld;
    logic [DW-1:0]     w_dat [STAGES];
    logic [STAGES:0]   w_rdy;

    assign w_s        = in_a[W-1];
    assign w_sb       = in_b[W-1];
    assign w_mag      = in_a[W-2:0];
    assign w_unused_b = ^in_b[W-2:0];

    // Sign selection; only the sign bit ever changes, so NaN payloads pass untouched.
    always_comb begin
        w_new_sign = w_s;
        case (in_op)
            OP_MOV:  w_new_sign = w_s;
            OP_NEG:  w_new_sign = ((NEG_ZERO_POS != 0) && (w_mag == '0)) ? 1'b0 : ~w_s;
            OP_ABS:  w_new_sign = 1'b0;
            OP_CPS:  w_new_sign = w_sb;
            OP_NCPS: w_new_sign = ~w_sb;
            OP_XORS: w_new_sign = w_s ^ w_sb;
            default: w_new_sign = w_s;
        endcase
    end

    assign w_res  = {w_new_sign, w_mag};
    assign w_cls  = fp_classify(FP_EXP_MAX'(in_a[W-2 -: EXP_W]),
                                FP_MAN_MAX'(in_a[MAN_W-1:0]), EXP_W, MAN_W);
    assign w_pack = {w_res, in_tag, w_cls};

    // Holds the input closed until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    // Backward ready chain: a slice accepts if it is empty or everything after it moves.
    always_comb begin
        logic acc;
        acc   = out_ready;
        w_rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_rdy[k+1] = acc;
            acc        = ~w_vld[k] | acc;
        end
        w_rdy[0] = acc;
    end

    assign in_ready = r_rst_done & w_rdy[0];

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic          w_iv;
            logic [DW-1:0] w_id;
            if (k == 0) begin : g_first
                assign w_iv = in_valid & r_rst_done;
                assign w_id = w_pack;
            end else begin : g_next
                assign w_iv = w_vld[k-1];
                assign w_id = w_dat[k-1];
            end
            fp_pipe_slice #(.DW(DW)) u_slice (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_valid (w_iv),
                .i_data  (w_id),
                .i_ready (w_rdy[k+1]),
                .o_valid (w_vld[k]),
                .o_data  (w_dat[k])
            );
        end
    endgenerate

    assign out_valid  = w_vld[STAGES-1];
    assign out_result = w_dat[STAGES-1][DW-1 -: W];
    assign out_tag    = w_dat[STAGES-1][FP_CLASS_W +: TAG_W];
    assign w_out_cls  = fp_class_t'(w_dat[STAGES-1][FP_CLASS_W-1:0]);
    assign out_qnan   = w_out_cls.qnan;
    assign out_snan   = w_out_cls.snan;
    assign out_inf    = w_out_cls.inf;
    assign out_zero   = w_out_cls.zero;
    assign out_subn   = w_out_cls.subn;

endmodule

// File: tb/tb_fp_sign_unit_pipe.sv
// Bench for fp_sign_unit_pipe: directed vector table, streaming/backpressure runs
// against a reference model, reset-in-flight check and a double-precision instance.
module tb_fp_sign_unit_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // single precision, NEG_ZERO_POS=1, 2 stages
    logic        s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0;
    logic [2:0]  s_in_op = 0;
    logic [31:0] s_in_a = 0, s_in_b = 0, s_out_result;
    logic [4:0]  s_in_tag = 0, s_out_tag;
    logic        s_qnan, s_snan, s_inf, s_zero, s_subn;

    // double precision, NEG_ZERO_POS=0, 3 stages
    logic        d_in_valid = 0, d_in_ready, d_out_valid, d_out_ready = 0;
    logic [2:0]  d_in_op = 0;
    logic [63:0] d_in_a = 0, d_in_b = 0, d_out_result;
    logic [4:0]  d_in_tag = 0, d_out_tag;
    logic        d_qnan, d_snan, d_inf, d_zero, d_subn;

    fp_sign_unit_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_op(s_in_op), .in_a(s_in_a), .in_b(s_in_b), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_result(s_out_result),
        .out_tag(s_out_tag), .out_qnan(s_qnan), .out_snan(s_snan), .out_inf(s_inf),
        .out_zero(s_zero), .out_subn(s_subn)
    );

    fp_sign_unit_pipe #(.EXP_W(11), .MAN_W(52), .STAGES(3), .TAG_W(5), .NEG_ZERO_POS(0)) u_dut_dbl (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .in_op(d_in_op), .in_a(d_in_a), .in_b(d_in_b), .in_tag(d_in_tag),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_result(d_out_result),
        .out_tag(d_out_tag), .out_qnan(d_qnan), .out_snan(d_snan), .out_inf(d_inf),
        .out_zero(d_zero), .out_subn(d_subn)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Flags order: {qnan, snan, inf, zero, subn}
    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        logic [4:0]  tag;
    } exp_t;

    // Reference: restate the op table in terms of sign, magnitude and field values.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] tag);
        exp_t e;
        int unsigned expo, frac, mag;
        bit sa, sb, ns;
        sa   = a[31];
        sb   = b[31];
        mag  = a % 32'h8000_0000;
        expo = (a / 32'h0080_0000) % 256;
        frac = a % 32'h0080_0000;
        case (op)
            3'd1:    ns = (mag == 0) ? 1'b0 : !sa;
            3'd2:    ns = 1'b0;
            3'd3:    ns = sb;
            3'd4:    ns = !sb;
            3'd5:    ns = (sa != sb);
            default: ns = sa;
        endcase
        e.res = ns ? (mag + 32'h8000_0000) : mag;
        e.fl  = {(expo == 255 && frac >= 32'h40_0000),
                 (expo == 255 && frac != 0 && frac < 32'h40_0000),
                 (expo == 255 && frac == 0),
                 (expo == 0 && frac == 0),
                 (expo == 0 && frac != 0)};
        e.tag = tag;
        return e;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 4))
            0: e = 8'hFF;
            1: e = 8'h00;
            default: e = 8'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: f = '0;
            1: f = 23'h40_0000 | 23'($urandom_range(0, 3));
            default: f = 23'($urandom);
        endcase
        return {1'($urandom), e, f};
    endfunction

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    task automatic run_vec(input vec_t v, input logic [4:0] tag);
        int cyc;
        @(negedge clk);
        s_out_ready = 1; s_in_valid = 1; s_in_op = v.op; s_in_a = v.a; s_in_b = v.b; s_in_tag = tag;
        #1 chk({v.name, "_in_ready"}, s_in_ready, 1);
        @(negedge clk);
        s_in_valid = 0; s_in_a = 32'hDEAD_BEEF;
        cyc = 1;
        while (!s_out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({v.name, "_latency"}, cyc, 2);
        chk({v.name, "_result"}, s_out_result, v.res);
        chk({v.name, "_flags"}, {s_qnan, s_snan, s_inf, s_zero, s_subn}, v.fl);
        chk({v.name, "_tag"}, s_out_tag, tag);
    endtask

    task automatic run_dbl(input string name, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] res, input logic [4:0] fl);
        int cyc;
        @(negedge clk);
        d_out_ready = 1; d_in_valid = 1; d_in_op = op; d_in_a = a; d_in_b = '0; d_in_tag = 5'd9;
        @(negedge clk);
        d_in_valid = 0;
        cyc = 1;
        while (!d_out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, cyc, 3);
        chk({name, "_result"}, d_out_result, res);
        chk({name, "_flags"}, {d_qnan, d_snan, d_inf, d_zero, d_subn}, fl);
        chk({name, "_tag"}, d_out_tag, 5'd9);
    endtask

    // Stream n ops; rnd=0 -> valid every cycle, out_ready pattern 1,0,0,1; rnd=1 -> random both.
    task automatic run_stream(input int n, input bit rnd);
        localparam bit [3:0] PAT = 4'b1001;
        exp_t        q[$];
        exp_t        e;
        int          sent = 0, got = 0, occ = 0, cyc = 0;
        bit          stall = 0, ofire;
        logic [31:0] h_res;
        logic [4:0]  h_tag;
        while (got < n && cyc < 20 * n + 50) begin
            @(negedge clk);
            if (stall) begin
                chk("hold_valid", s_out_valid, 1);
                chk("hold_result", s_out_result, h_res);
                chk("hold_tag", s_out_tag, h_tag);
            end
            s_out_ready = rnd ? ($urandom_range(0, 3) != 0) : PAT[cyc % 4];
            s_in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            s_in_op     = rnd ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
            s_in_a      = rand_fp();
            s_in_b      = $urandom;
            s_in_tag    = 5'(sent);
            cyc++;
            #1;
            chk("in_ready", s_in_ready, !(occ == 2 && !s_out_ready));
            ofire = s_out_valid && s_out_ready;
            if (ofire) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("stream_result", s_out_result, e.res);
                    chk("stream_flags", {s_qnan, s_snan, s_inf, s_zero, s_subn}, e.fl);
                    chk("stream_tag", s_out_tag, e.tag);
                end
                got++;
            end
            stall = s_out_valid && !s_out_ready;
            h_res = s_out_result;
            h_tag = s_out_tag;
            if (s_in_valid && s_in_ready) begin
                q.push_back(model(s_in_op, s_in_a, s_in_b, s_in_tag));
                sent++;
                occ++;
            end
            if (ofire) occ--;
        end
        chk("stream_all_received", got, n);
        @(negedge clk);
        s_in_valid = 0;
        s_out_ready = 1;
    endtask

    vec_t vecs[13];

    initial begin
        bit seen;
        vecs[0]  = '{"neg_one",    3'd1, 32'h3F800000, 32'h0,        32'hBF800000, 5'b00000};
        vecs[1]  = '{"neg_qnan",   3'd1, 32'h7FC00001, 32'h0,        32'hFFC00001, 5'b10000};
        vecs[2]  = '{"neg_snan",   3'd1, 32'h7F800001, 32'h0,        32'hFF800001, 5'b01000};
        vecs[3]  = '{"neg_pzero",  3'd1, 32'h00000000, 32'h0,        32'h00000000, 5'b00010};
        vecs[4]  = '{"neg_nzero",  3'd1, 32'h80000000, 32'h0,        32'h00000000, 5'b00010};
        vecs[5]  = '{"copysign",   3'd3, 32'h40490FDB, 32'h80000000, 32'hC0490FDB, 5'b00000};
        vecs[6]  = '{"xorsign",    3'd5, 32'hC0000000, 32'h80000000, 32'h40000000, 5'b00000};
        vecs[7]  = '{"abs_ninf",   3'd2, 32'hFF800000, 32'h0,        32'h7F800000, 5'b00100};
        vecs[8]  = '{"ncopysign",  3'd4, 32'h3F800000, 32'h00000000, 32'hBF800000, 5'b00000};
        vecs[9]  = '{"mov_subn",   3'd0, 32'h00000001, 32'h80000000, 32'h00000001, 5'b00001};
        vecs[10] = '{"resv_op",    3'd7, 32'hFFC00000, 32'h0,        32'hFFC00000, 5'b10000};
        vecs[11] = '{"abs_nzero",  3'd2, 32'h80000000, 32'h0,        32'h00000000, 5'b00010};
        vecs[12] = '{"neg_subn",   3'd1, 32'h80000001, 32'h0,        32'h00000001, 5'b00001};

        repeat (3) @(negedge clk);
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_in_ready", s_in_ready, 0);
        chk("rst_result", s_out_result, 0);
        chk("rst_flags_tag", {s_qnan, s_snan, s_inf, s_zero, s_subn, s_out_tag}, 0);
        chk("rst_dbl_valid", d_out_valid, 0);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", s_in_ready, 1);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], 5'(i + 3));

        run_dbl("dbl_neg_one",  3'd1, 64'h3FF0000000000000, 64'hBFF0000000000000, 5'b00000);
        run_dbl("dbl_neg_zero", 3'd1, 64'h0000000000000000, 64'h8000000000000000, 5'b00010);
        run_dbl("dbl_neg_qnan", 3'd1, 64'h7FF8000000000000, 64'hFFF8000000000000, 5'b10000);
        run_dbl("dbl_neg_snan", 3'd1, 64'h7FF0000000000001, 64'hFFF0000000000001, 5'b01000);

        run_stream(8, 1'b0);
        run_stream(300, 1'b1);

        // two ops in flight, stalled, then reset
        @(negedge clk);
        s_out_ready = 0; s_in_valid = 1; s_in_op = 3'd1; s_in_a = 32'h3F800000; s_in_tag = 5'd1;
        @(negedge clk);
        s_in_tag = 5'd2;
        @(negedge clk);
        s_in_valid = 0;
        #1 chk("inflight_valid", s_out_valid, 1);
        rst_n = 0;
        #1;
        chk("rst_mid_out_valid", s_out_valid, 0);
        chk("rst_mid_in_ready", s_in_ready, 0);
        chk("rst_mid_result", s_out_result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        s_out_ready = 1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (s_out_valid) seen = 1;
        end
        chk("no_stale_beat", seen, 0);
        run_vec(vecs[0], 5'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
